gravity_drop_animator: RTL

GRAVITY_DROP_ANIMATOR -- requirements
Module: gravity_drop_animator

---
 rtl/gravity_drop_animator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gravity_drop_animator.sv
// Animates a falling token down one board column, one row per TICKS+1 cycles, then reports where it landed.
// Optional macro DROP_ACCEL_EN: each row step halves the hold time (floored at 1) so the token speeds up.
module gravity_drop_animator #(
  parameter int ROWS   = 6,
  parameter int COLS   = 7,
  parameter int DISP_W = 16,
  parameter int DISP_H = 16,
  parameter int TICKS  = 2000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ROWS-1:0][DISP_W-1:0]         board_red,
  input  logic [ROWS-1:0][DISP_W-1:0]         board_grn,
  input  logic                                req_valid,
  input  logic                                req_player,
  input  logic [$clog2(COLS)-1:0]             req_col,
  input  logic                                cancel,
  output logic                                req_ready,
  output logic [DISP_H-1:0][DISP_W-1:0]       anim_red,
  output logic [DISP_H-1:0][DISP_W-1:0]       anim_grn,
  output logic                                busy,
  output logic                                done,
  output logic                                reject,
  output logic [$clog2(ROWS)-1:0]             done_row,
  output logic [$clog2(COLS)-1:0]             done_col
);

  // state | meaning
  // IDLE  | waiting for a drop request; req_ready high
  // HOLD  | token shown at r_row, timer counting down to 0
  // STEP  | timer==0 decision (fall one row or land); decided on that same edge, never held
  typedef enum logic [1:0] {IDLE, HOLD, STEP} state_t;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TICKS + 1);
  localparam logic [TW-1:0]     TICKS_T  = TW'(TICKS);
  localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW:0]       COLS_W   = (CW + 1)'(COLS);
  localparam logic [DISP_W-1:0] MSB      = {1'b1, {(DISP_W - 1){1'b0}}};

  state_t              r_state, w_state_n, w_phase;
  logic [RW-1:0]       r_row, w_row_n, w_row_p1;
  logic [CW-1:0]       r_col, w_col_n;
  logic                r_player, w_player_n;
  logic [TW-1:0]       r_timer, w_timer_n, w_step_load;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic                r_reject, w_reject_n;
  logic [RW-1:0]       r_done_row, w_done_row_n;
  logic [CW-1:0]       r_done_col, w_done_col_n;
  logic [DISP_H-1:0][DISP_W-1:0] r_anim_red, r_anim_grn, w_anim_red_n, w_anim_grn_n;
  logic                w_accept, w_move, w_col_ok, w_top_occ, w_below_occ;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_col_ok  = {1'b0, req_col} < COLS_W;
  assign w_top_occ = |((board_red[0] | board_grn[0]) & (MSB >> req_col));
  assign w_row_p1  = r_row + 1'b1;
  // Only meaningful when r_row is not the last row; the STEP branch checks that first.
  assign w_below_occ = |((board_red[w_row_p1] | board_grn[w_row_p1]) & (MSB >> r_col));
  assign w_phase   = (r_state == HOLD && r_timer == '0) ? STEP : r_state;

`ifdef DROP_ACCEL_EN
  logic [TW-1:0] r_reload;

  assign w_step_load = (r_reload > TW'(1)) ? (r_reload >> 1) : TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= '0;
    end else if (w_accept) begin
      r_reload <= TICKS_T;
    end else if (w_move) begin
      r_reload <= w_step_load;
    end
  end
`else
  assign w_step_load = TICKS_T;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_row_n      = r_row;
    w_col_n      = r_col;
    w_player_n   = r_player;
    w_timer_n    = r_timer;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_reject_n   = 1'b0;
    w_done_row_n = r_done_row;
    w_done_col_n = r_done_col;
    w_move       = 1'b0;
    if (cancel && r_state != IDLE) begin
      w_state_n = IDLE;
      w_busy_n  = 1'b0;
      w_timer_n = '0;
    end else begin
      case (w_phase)
        IDLE: begin
          if (w_accept) begin
            if (!w_col_ok || w_top_occ) begin
              w_reject_n = 1'b1;
            end else begin
              w_state_n  = HOLD;
              w_player_n = req_player;
              w_col_n    = req_col;
              w_row_n    = '0;
              w_timer_n  = TICKS_T;
              w_busy_n   = 1'b1;
            end
          end
        end
        HOLD: w_timer_n = r_timer - 1'b1;
        STEP: begin
          if (r_row != LAST_ROW && !w_below_occ) begin
            w_row_n   = w_row_p1;
            w_timer_n = w_step_load;
            w_state_n = HOLD;
            w_move    = 1'b1;
          end else begin
            w_done_n     = 1'b1;
            w_done_row_n = r_row;
            w_done_col_n = r_col;
            w_busy_n     = 1'b0;
            w_state_n    = IDLE;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_anim_red_n = '0;
    w_anim_grn_n = '0;
    if (w_busy_n) begin
      if (w_player_n) w_anim_grn_n[w_row_n] = MSB >> w_col_n;
      else            w_anim_red_n[w_row_n] = MSB >> w_col_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_player   <= 1'b0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reject   <= 1'b0;
      r_done_row <= '0;
      r_done_col <= '0;
      r_anim_red <= '0;
      r_anim_grn <= '0;
    end else begin
      r_state    <= w_state_n;
      r_row      <= w_row_n;
      r_col      <= w_col_n;
      r_player   <= w_player_n;
      r_timer    <= w_timer_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_reject   <= w_reject_n;
      r_done_row <= w_done_row_n;
      r_done_col <= w_done_col_n;
      r_anim_red <= w_anim_red_n;
      r_anim_grn <= w_anim_grn_n;
    end
  end

  assign anim_red = r_anim_red;
  assign anim_grn = r_anim_grn;
  assign busy     = r_busy;
  assign done     = r_done;
  assign reject   = r_reject;
  assign done_row = r_done_row;
  assign done_col = r_done_col;

endmodule
